// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word/line widths and the L2 arbiter state.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } l2_arb_state_t;

endpackage

// File: rtl/l2_arbiter_control.sv
// Grant FSM for the shared L2 port: picks a requester in IDLE, holds the
// grant until l2_resp, then always returns through IDLE so the served side
// can drop its request before the next arbitration. prio flips to the other
// side after every completed transaction, giving strict alternation under
// contention.
module l2_arbiter_control
    import lc3b_types::*;
#(
    parameter logic I_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    input  logic l2_resp,
    output logic sel_d,
    output logic busy
);

    l2_arb_state_t state_q, state_d;
    logic          prio_q, prio_d;   // 1 = I-side wins the next contention

    // State and priority registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= I_FIRST;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Next-state: arbitrate only from IDLE; a grant ends only on l2_resp.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                // l2_resp here is stray and deliberately ignored
                if (i_req && (!d_req || prio_q))
                    state_d = GNT_I;
                else if (d_req)
                    state_d = GNT_D;
            end
            GNT_I: begin
                if (l2_resp) begin
                    state_d = IDLE;
                    prio_d  = 1'b0;
                end
            end
            GNT_D: begin
                if (l2_resp) begin
                    state_d = IDLE;
                    prio_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign sel_d = (state_q == GNT_D);

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the I-cache (line fills) and the
// D-cache (fills and write-backs). The control block owns the grant; this
// level steers the request toward L2 and routes l2_resp to the granted side.
module l2_arbiter
    import lc3b_types::*;
#(
    parameter logic I_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            i_l2_read,
    input  logic [15:0]     i_l2_addr,
    output logic            i_l2_resp,
    output logic [127:0]    i_l2_rdata,

    input  logic            d_l2_read,
    input  logic            d_l2_write,
    input  logic [15:0]     d_l2_addr,
    input  logic [127:0]    d_l2_wdata,
    output logic            d_l2_resp,
    output logic [127:0]    d_l2_rdata,

    output logic            l2_read,
    output logic            l2_write,
    output logic [15:0]     l2_addr,
    output logic [127:0]    l2_wdata,
    input  logic            l2_resp,
    input  logic [127:0]    l2_rdata
);

    logic sel_d;
    logic busy;
    logic gnt_i;

    l2_arbiter_control #(
        .I_FIRST (I_FIRST)
    ) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_l2_read),
        .d_req   (d_l2_read | d_l2_write),
        .l2_resp (l2_resp),
        .sel_d   (sel_d),
        .busy    (busy)
    );

    assign gnt_i = busy & ~sel_d;

    // Downstream request mux; everything is zero while nobody is granted.
    // A D-side read+write collision is resolved as a write.
    always_comb begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
        l2_addr  = '0;
        l2_wdata = '0;
        if (gnt_i) begin
            l2_read = 1'b1;
            l2_addr = i_l2_addr;
        end else if (sel_d) begin
            l2_read  = d_l2_read & ~d_l2_write;
            l2_write = d_l2_write;
            l2_addr  = d_l2_addr;
            l2_wdata = d_l2_wdata;
        end
    end

    // Completion goes only to the side holding the grant.
    always_comb begin
        i_l2_resp = gnt_i & l2_resp;
        d_l2_resp = sel_d & l2_resp;
    end

    assign i_l2_rdata = l2_rdata;
    assign d_l2_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: two instances (I_FIRST=0 at index 0, I_FIRST=1 at
// index 1), a transaction-level model of who is being served, and a
// negedge compare process, plus literal expectations from the test plan.
module tb_l2_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         i_rd   [2];
    logic [15:0]  i_addr [2];
    logic         d_rd   [2];
    logic         d_wr   [2];
    logic [15:0]  d_addr [2];
    logic [127:0] wdata  [2];
    logic         resp   [2];
    logic [127:0] rdata  [2];

    logic         o_iresp [2];
    logic [127:0] o_irdat [2];
    logic         o_dresp [2];
    logic [127:0] o_drdat [2];
    logic         o_rd    [2];
    logic         o_wr    [2];
    logic [15:0]  o_addr  [2];
    logic [127:0] o_wdata [2];

    l2_arbiter #(.I_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_l2_read(i_rd[0]), .i_l2_addr(i_addr[0]),
        .i_l2_resp(o_iresp[0]), .i_l2_rdata(o_irdat[0]),
        .d_l2_read(d_rd[0]), .d_l2_write(d_wr[0]), .d_l2_addr(d_addr[0]),
        .d_l2_wdata(wdata[0]), .d_l2_resp(o_dresp[0]), .d_l2_rdata(o_drdat[0]),
        .l2_read(o_rd[0]), .l2_write(o_wr[0]), .l2_addr(o_addr[0]),
        .l2_wdata(o_wdata[0]), .l2_resp(resp[0]), .l2_rdata(rdata[0])
    );

    l2_arbiter #(.I_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_l2_read(i_rd[1]), .i_l2_addr(i_addr[1]),
        .i_l2_resp(o_iresp[1]), .i_l2_rdata(o_irdat[1]),
        .d_l2_read(d_rd[1]), .d_l2_write(d_wr[1]), .d_l2_addr(d_addr[1]),
        .d_l2_wdata(wdata[1]), .d_l2_resp(o_dresp[1]), .d_l2_rdata(o_drdat[1]),
        .l2_read(o_rd[1]), .l2_write(o_wr[1]), .l2_addr(o_addr[1]),
        .l2_wdata(o_wdata[1]), .l2_resp(resp[1]), .l2_rdata(rdata[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chks(input string nm, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=\"%s\" want=\"%s\"", nm, act, exp);
        end
    endtask

    // Model: owner 0 = nobody, 1 = I-cache, 2 = D-cache; ipref says whether
    // I wins a tie. The side just served loses the next tie.
    int   own   [2];
    logic ipref [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own[0]   <= 0;
            own[1]   <= 0;
            ipref[0] <= 1'b0;
            ipref[1] <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (own[k] == 0) begin
                    if (i_rd[k] && (!(d_rd[k] || d_wr[k]) || ipref[k]))
                        own[k] <= 1;
                    else if (d_rd[k] || d_wr[k])
                        own[k] <= 2;
                end else if (resp[k]) begin
                    ipref[k] <= (own[k] == 2);
                    own[k]   <= 0;
                end
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                assert (!(d_rd[k] && d_wr[k])) else $error("protocol: d read+write together");
                chk($sformatf("l2_read[%0d]", k), {127'd0, o_rd[k]},
                    {127'd0, (own[k] == 1) || (own[k] == 2 && d_rd[k] && !d_wr[k])});
                chk($sformatf("l2_write[%0d]", k), {127'd0, o_wr[k]},
                    {127'd0, own[k] == 2 && d_wr[k]});
                chk($sformatf("l2_addr[%0d]", k), {112'd0, o_addr[k]},
                    {112'd0, own[k] == 1 ? i_addr[k] : own[k] == 2 ? d_addr[k] : 16'h0});
                chk($sformatf("l2_wdata[%0d]", k), o_wdata[k],
                    own[k] == 2 ? wdata[k] : 128'd0);
                chk($sformatf("i_resp[%0d]", k), {127'd0, o_iresp[k]},
                    {127'd0, own[k] == 1 && resp[k]});
                chk($sformatf("d_resp[%0d]", k), {127'd0, o_dresp[k]},
                    {127'd0, own[k] == 2 && resp[k]});
                if (o_iresp[k]) chk($sformatf("i_rdata[%0d]", k), o_irdat[k], rdata[k]);
                if (o_dresp[k]) chk($sformatf("d_rdata[%0d]", k), o_drdat[k], rdata[k]);
            end
        end
    end

    // Requester / L2 responder stimulus.
    int    pend_i [2];
    int    pend_d [2];
    logic  dmode  [2];   // 1 = D requests are write-backs
    int    rd_cyc, wr_cyc;
    string ord;

    task automatic run(input int k, input int lat, input int maxc);
        int   cnt;
        logic gi, gd;
        cnt = 0; gi = 1'b0; gd = 1'b0;
        rd_cyc = 0; wr_cyc = 0; ord = "";
        for (int c = 0; c < maxc; c++) begin
            @(posedge clk); #1;
            if (gi) pend_i[k]--;
            if (gd) pend_d[k]--;
            i_rd[k] = pend_i[k] > 0;
            d_rd[k] = pend_d[k] > 0 && !dmode[k];
            d_wr[k] = pend_d[k] > 0 && dmode[k];
            resp[k] = 1'b0;
            if (pend_i[k] == 0 && pend_d[k] == 0) break;
            #1;
            if (o_rd[k]) rd_cyc++;
            if (o_wr[k]) wr_cyc++;
            if (o_rd[k] || o_wr[k]) begin
                cnt++;
                if (cnt >= lat) begin
                    resp[k] = 1'b1;
                    cnt = 0;
                end
            end
            @(negedge clk);
            gi = o_iresp[k];
            gd = o_dresp[k];
            if (gi) ord = {ord, "I"};
            if (gd) ord = {ord, "D"};
        end
        if (pend_i[k] != 0 || pend_d[k] != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout[%0d] pending i=%0d d=%0d want 0", k, pend_i[k], pend_d[k]);
        end
        resp[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            i_rd[k] = 0; d_rd[k] = 0; d_wr[k] = 0; resp[k] = 0;
            i_addr[k] = 0; d_addr[k] = 0; wdata[k] = 0;
            pend_i[k] = 0; pend_d[k] = 0; dmode[k] = 0;
        end
        rdata[0] = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        rdata[1] = 128'hdeadbeef_cafef00d_12345678_9abcdef0;

        // Reset state
        #1;
        chk("rst l2_read", {127'd0, o_rd[1]}, 128'd0);
        chk("rst l2_write", {127'd0, o_wr[1]}, 128'd0);
        chk("rst l2_addr", {112'd0, o_addr[1]}, 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention on I_FIRST=1: alternates starting with I
        i_addr[1] = 16'h1110; d_addr[1] = 16'h2220; wdata[1] = {16{8'h3C}};
        pend_i[1] = 2; pend_d[1] = 2; dmode[1] = 1'b0;
        run(1, 1, 40);
        chks("order ifirst1", ord, "IDID");

        // Contention on I_FIRST=0: alternates starting with D
        i_addr[0] = 16'h0AA0; d_addr[0] = 16'h0BB0;
        pend_i[0] = 2; pend_d[0] = 2; dmode[0] = 1'b0;
        run(0, 2, 40);
        chks("order ifirst0", ord, "DIDI");

        // Lone I read, 3-cycle latency
        i_addr[1] = 16'h1230; pend_i[1] = 1;
        run(1, 3, 20);
        chk("lone I read cycles", rd_cyc, 3);
        chks("lone I order", ord, "I");

        // Lone D write-back
        d_addr[1] = 16'h4560; wdata[1] = {16{8'hA5}}; dmode[1] = 1'b1; pend_d[1] = 1;
        run(1, 2, 20);
        chk("lone D write cycles", wr_cyc, 2);
        chk("lone D read cycles", rd_cyc, 0);
        chks("lone D order", ord, "D");

        // Stray l2_resp in IDLE
        @(posedge clk); #1;
        resp[1] = 1'b1;
        @(negedge clk);
        chk("stray i_resp", {127'd0, o_iresp[1]}, 128'd0);
        chk("stray d_resp", {127'd0, o_dresp[1]}, 128'd0);
        @(posedge clk); #1;
        resp[1] = 1'b0;
        i_addr[1] = 16'h1234; pend_i[1] = 1;
        run(1, 1, 20);
        chks("after stray order", ord, "I");

        // Async reset in the middle of a D write-back
        @(posedge clk); #1;
        d_addr[1] = 16'h7770; d_wr[1] = 1'b1;
        @(posedge clk); #2;
        chk("pre-reset l2_write", {127'd0, o_wr[1]}, 128'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst l2_write", {127'd0, o_wr[1]}, 128'd0);
        chk("async rst l2_read", {127'd0, o_rd[1]}, 128'd0);
        chk("async rst l2_addr", {112'd0, o_addr[1]}, 128'd0);
        d_wr[1] = 1'b0;
        i_addr[1] = 16'h2468; i_rd[1] = 1'b1;
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst grant read", {127'd0, o_rd[1]}, 128'd1);
        chk("post-rst grant addr", {112'd0, o_addr[1]}, {112'd0, 16'h2468});
        pend_i[1] = 1;
        run(1, 1, 20);
        chks("post-rst order", ord, "I");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
